// File: rtl/matrix_elem_streamer.sv
// matrix_elem_streamer
// Streams a latched packed matrix out one element at a time in row-major
// order over a valid/ready handshake, tagging each element with its row and
// column and flagging end-of-row and end-of-matrix.
module matrix_elem_streamer #(
    parameter int MAX_DIM    = 5,
    parameter int ELEM_WIDTH = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [2:0]                            m,
    input  logic [2:0]                            n,
    input  logic [MAX_DIM*MAX_DIM*ELEM_WIDTH-1:0] matrix_in,
    output logic [ELEM_WIDTH-1:0]                 out_data,
    output logic [2:0]                            out_row,
    output logic [2:0]                            out_col,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  out_last_col,
    output logic                                  out_last,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err
);

    localparam int NELEM = MAX_DIM * MAX_DIM;
    localparam int MAT_W = NELEM * ELEM_WIDTH;
    localparam int IDXW  = $clog2(NELEM);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [MAT_W-1:0]      r_mat;
    logic [2:0]            r_m;
    logic [2:0]            r_n;
    logic [2:0]            r_row;
    logic [2:0]            r_col;

    logic [ELEM_WIDTH-1:0] r_out_data;
    logic [2:0]            r_out_row;
    logic [2:0]            r_out_col;
    logic                  r_out_valid;
    logic                  r_out_last_col;
    logic                  r_out_last;
    logic                  r_err;

    logic                  w_dims_ok;
    logic                  w_at_last_col;
    logic                  w_at_last;
    logic                  w_load;
    logic                  w_err_nxt;
    logic [2:0]            w_row_nxt;
    logic [2:0]            w_col_nxt;

    logic [MAT_W-1:0]      w_src;
    logic [2:0]            w_m_sel;
    logic [2:0]            w_n_sel;
    logic [IDXW-1:0]       w_idx;
    logic [ELEM_WIDTH-1:0] w_elem;
    logic                  w_last_col_nxt;
    logic                  w_last_nxt;

    // Dimension validation on the incoming request and position of the
    // element currently presented.
    always_comb begin
        w_dims_ok     = (m != 3'd0) && (m <= 3'(MAX_DIM)) &&
                        (n != 3'd0) && (n <= 3'(MAX_DIM));
        w_at_last_col = (r_col == (r_n - 3'd1));
        w_at_last     = w_at_last_col && (r_row == (r_m - 3'd1));
    end

    // Next-state logic: request handling, row-major walk and the done step.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_err_nxt   = 1'b0;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_dims_ok) begin
                        w_load      = 1'b1;
                        w_row_nxt   = 3'd0;
                        w_col_nxt   = 3'd0;
                        w_state_nxt = S_SEND;
                    end else begin
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    if (w_at_last) begin
                        w_state_nxt = S_DONE;
                    end else if (w_at_last_col) begin
                        w_col_nxt = 3'd0;
                        w_row_nxt = r_row + 3'd1;
                    end else begin
                        w_col_nxt = r_col + 3'd1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The element for the next cycle is fetched from matrix_in directly on
    // the load cycle so (0,0) is presented in the very next cycle.
    always_comb begin
        w_src   = w_load ? matrix_in : r_mat;
        w_m_sel = w_load ? m : r_m;
        w_n_sel = w_load ? n : r_n;
        w_idx   = IDXW'(w_row_nxt) * IDXW'(MAX_DIM) + IDXW'(w_col_nxt);
    end

    // Element multiplexer over the packed matrix.
    always_comb begin
        w_elem = '0;
        for (int unsigned k = 0; k < NELEM; k++) begin
            if (w_idx == IDXW'(k)) begin
                w_elem = w_src[k*ELEM_WIDTH +: ELEM_WIDTH];
            end
        end
    end

    // End-of-row and end-of-matrix flags for the next presented element.
    always_comb begin
        w_last_col_nxt = (w_col_nxt == (w_n_sel - 3'd1));
        w_last_nxt     = w_last_col_nxt && (w_row_nxt == (w_m_sel - 3'd1));
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Walk counters, latched dimensions and latched matrix.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row <= '0;
            r_col <= '0;
            r_m   <= '0;
            r_n   <= '0;
            r_mat <= '0;
        end else begin
            r_row <= w_row_nxt;
            r_col <= w_col_nxt;
            if (w_load) begin
                r_m   <= m;
                r_n   <= n;
                r_mat <= matrix_in;
            end
        end
    end

    // Registered stream outputs; recomputed from unchanged counters while
    // stalled, so they hold stable until the transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_row      <= '0;
            r_out_col      <= '0;
            r_out_last_col <= 1'b0;
            r_out_last     <= 1'b0;
        end else if (w_state_nxt == S_SEND) begin
            r_out_valid    <= 1'b1;
            r_out_data     <= w_elem;
            r_out_row      <= w_row_nxt;
            r_out_col      <= w_col_nxt;
            r_out_last_col <= w_last_col_nxt;
            r_out_last     <= w_last_nxt;
        end else begin
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_row      <= '0;
            r_out_col      <= '0;
            r_out_last_col <= 1'b0;
            r_out_last     <= 1'b0;
        end
    end

    // Invalid-dimension pulse register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end

    assign out_data     = r_out_data;
    assign out_row      = r_out_row;
    assign out_col      = r_out_col;
    assign out_valid    = r_out_valid;
    assign out_last_col = r_out_last_col;
    assign out_last     = r_out_last;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign err          = r_err;

endmodule

// File: tb/tb_matrix_elem_streamer.sv
// Testbench for matrix_elem_streamer: directed and randomized streams
// checked against a row-major reference queue built in the bench.
module tb_matrix_elem_streamer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   m;
    logic [2:0]   n;
    logic [199:0] matrix_in;
    logic [7:0]   out_data;
    logic [2:0]   out_row;
    logic [2:0]   out_col;
    logic         out_valid;
    logic         out_ready;
    logic         out_last_col;
    logic         out_last;
    logic         busy;
    logic         done;
    logic         err;

    int errors = 0;
    int checks = 0;

    int unsigned mat_e [25];

    typedef struct {
        int data;
        int row;
        int col;
        int lc;
        int l;
    } exp_t;

    exp_t q [$];

    matrix_elem_streamer #(.MAX_DIM(5), .ELEM_WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .m            (m),
        .n            (n),
        .matrix_in    (matrix_in),
        .out_data     (out_data),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last_col (out_last_col),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [199:0] pack_matrix();
        logic [199:0] v;
        v = '0;
        for (int i = 0; i < 25; i++) v[i*8 +: 8] = mat_e[i][7:0];
        return v;
    endfunction

    task automatic randomize_matrix();
        for (int i = 0; i < 25; i++) mat_e[i] = $urandom_range(0, 255);
    endtask

    // mode: 0 ready always, 1 random ready, 2 low for 3 cycles then toggling.
    // perturb_at: transfer index at which inputs change and start re-pulses.
    // reset_after: transfer count after which reset is asserted mid-stream.
    task automatic run_stream(input int mm, input int nn, input int mode,
                              input int perturb_at, input int reset_after);
        exp_t e;
        int   k;
        int   cyc;
        bit   rdy;
        bit   perturbed;
        q.delete();
        for (int i = 0; i < mm; i++) begin
            for (int j = 0; j < nn; j++) begin
                e.data = int'(mat_e[i*5 + j]);
                e.row  = i;
                e.col  = j;
                e.lc   = (j == nn - 1) ? 1 : 0;
                e.l    = (i == mm - 1 && j == nn - 1) ? 1 : 0;
                q.push_back(e);
            end
        end
        @(negedge clk);
        start     = 1'b1;
        m         = mm[2:0];
        n         = nn[2:0];
        matrix_in = pack_matrix();
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        start     = 1'b0;
        k         = 0;
        cyc       = 0;
        perturbed = 1'b0;
        while (k < q.size() && cyc < 500) begin
            if (k == reset_after) begin
                reset = 1'b1;
                #1;
                check("rst_valid", 32'(out_valid), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_data", 32'(out_data), 0);
                check("rst_done", 32'(done), 0);
                @(negedge clk);
                check("rst_hold_done", 32'(done), 0);
                check("rst_hold_valid", 32'(out_valid), 0);
                reset = 1'b0;
                return;
            end
            check("valid", 32'(out_valid), 1);
            check("busy", 32'(busy), 1);
            check("done_mid", 32'(done), 0);
            check("err_mid", 32'(err), 0);
            check("data", 32'(out_data), q[k].data);
            check("row", 32'(out_row), q[k].row);
            check("col", 32'(out_col), q[k].col);
            check("last_col", 32'(out_last_col), q[k].lc);
            check("last", 32'(out_last), q[k].l);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc < 3) ? 1'b0 : 1'(cyc % 2);
            endcase
            if (k == perturb_at && !perturbed) begin
                start     = 1'b1;
                matrix_in = ~matrix_in;
                m         = 3'($urandom_range(0, 7));
                n         = 3'($urandom_range(0, 7));
                perturbed = 1'b1;
            end else begin
                start = 1'b0;
            end
            out_ready = rdy;
            @(negedge clk);
            if (rdy) k++;
            cyc++;
        end
        start = 1'b0;
        check("transfers", 32'(k), 32'(q.size()));
        check("done_pulse", 32'(done), 1);
        check("done_busy", 32'(busy), 1);
        check("done_valid", 32'(out_valid), 0);
        check("done_err", 32'(err), 0);
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("post_done", 32'(done), 0);
        check("post_busy", 32'(busy), 0);
        check("post_valid", 32'(out_valid), 0);
    endtask

    task automatic bad_start(input int mm, input int nn);
        @(negedge clk);
        start = 1'b1;
        m     = mm[2:0];
        n     = nn[2:0];
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", 32'(err), 1);
        check("err_busy", 32'(busy), 0);
        check("err_valid", 32'(out_valid), 0);
        @(negedge clk);
        check("err_clear", 32'(err), 0);
        check("err_busy2", 32'(busy), 0);
        check("err_valid2", 32'(out_valid), 0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        m         = '0;
        n         = '0;
        matrix_in = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_data", 32'(out_data), 0);
        check("reset_row", 32'(out_row), 0);
        check("reset_col", 32'(out_col), 0);
        check("reset_valid", 32'(out_valid), 0);
        check("reset_last_col", 32'(out_last_col), 0);
        check("reset_last", 32'(out_last), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_err", 32'(err), 0);
        reset = 1'b0;

        // 2x3 with element k = k+1 over the packed positions
        for (int i = 0; i < 25; i++) mat_e[i] = i + 1;
        run_stream(2, 3, 0, -1, -1);

        // backpressure on a 1x2 matrix
        randomize_matrix();
        mat_e[0] = 8'hAA;
        mat_e[1] = 8'h55;
        run_stream(1, 2, 2, -1, -1);

        // invalid dimensions
        bad_start(0, 3);
        bad_start(6, 2);
        bad_start(3, 7);

        // full size with inputs changed and start re-pulsed mid-stream
        for (int i = 0; i < 25; i++) mat_e[i] = i;
        run_stream(5, 5, 0, 7, -1);
        run_stream(5, 5, 1, 12, -1);

        // minimum size
        randomize_matrix();
        mat_e[0] = 8'h7F;
        run_stream(1, 1, 0, -1, -1);

        // reset after the 4th transfer of a 3x3, then a fresh stream
        randomize_matrix();
        run_stream(3, 3, 0, -1, 4);
        randomize_matrix();
        run_stream(3, 3, 0, -1, -1);

        // randomized dimensions, data and backpressure
        for (int t = 0; t < 12; t++) begin
            randomize_matrix();
            run_stream(int'($urandom_range(1, 5)), int'($urandom_range(1, 5)),
                       1, (t % 3 == 0) ? 2 : -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_elem_streamer.md
# matrix_elem_streamer

Serializes a packed result matrix into a stream of single elements, in row-major order, over a valid/ready handshake. It sits downstream of the scalar-multiply and other calculation units. It accepts their packed 200-bit matrix plus dimensions on a start pulse and feeds the display/output path one element per accepted transfer. Row/column tags and end-of-row/end-of-matrix flags travel with each element.

## Interface
- MAX_DIM, 5, maximum rows/columns; the dimension ports are 3 bits wide.
- ELEM_WIDTH, 8, bits per element; matrix_in is MAX_DIM*MAX_DIM*ELEM_WIDTH bits wide.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to stream the matrix presented this cycle.
- m  in  3  row count, valid range 1..MAX_DIM.
- n  in  3  column count, valid range 1..MAX_DIM.
- matrix_in  in  200  packed matrix; element (i,j) occupies bits [(i*MAX_DIM+j)*ELEM_WIDTH +: ELEM_WIDTH].
- out_data  out  8  current element.
- out_row  out  3  row index of out_data.
- out_col  out  3  column index of out_data.
- out_valid  out  1  out_data and its tags are valid.
- out_ready  in  1  consumer accepts; a transfer occurs when out_valid && out_ready.
- out_last_col  out  1  current element is column n-1.
- out_last  out  1  current element is (m-1, n-1).
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse after the final transfer.
- err  out  1  one-cycle pulse when start arrives with invalid dimensions.

## Operation
- States: IDLE, SEND, DONE.
- IDLE, start=1, 1<=m<=5 and 1<=n<=5:
  - Latch matrix_in, m and n into internal registers.
  - Set row=0, col=0.
  - Go to SEND.
- IDLE, start=1, dimensions invalid (m or n equal to 0 or greater than 5):
  - Pulse err for one cycle.
  - Latch nothing and stay in IDLE.
- SEND:
  - out_valid=1.
  - out_data = latched element (row, col).
  - out_row/out_col = row/col.
  - out_last_col = (col==n-1); out_last = (row==m-1 && col==n-1).
- Transfer that is not the last element:
  - If col==n-1: col=0, row=row+1.
  - Otherwise: col=col+1.
- Transfer on the last element: go to DONE.
- Without out_ready, every output holds stable. out_valid never drops before the transfer.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start is ignored in SEND and DONE. No err is raised for it and the latched data is unaffected.
- Changes on matrix_in, m or n after the start cycle do not affect the stream.
- Elements outside the m×n region are never emitted.
- Element values pass through unmodified. No arithmetic is performed.

## Timing
- Reset values:
  - out_data=0, out_row=0, out_col=0.
  - out_valid=0, out_last_col=0, out_last=0.
  - busy=0, done=0, err=0.
  - State IDLE; internal counters and latched matrix cleared.
- Reset asserted at any point, including mid-stream, forces all of the above immediately (asynchronously). The stream is abandoned and no done is produced.
- start sampled at edge T: out_valid=1 and busy=1 from T+1, with element (0,0) presented.
- With out_ready held high, one element transfers per cycle. The last transfer of an m×n matrix happens at edge T+m*n.
- done=1 in the cycle following the last transfer. busy stays 1 during the DONE cycle. busy=0 and a new start is accepted in the cycle after done.
- err is asserted in the cycle after the invalid start is sampled, for one cycle.
- Outputs are registered; out_ready has no combinational path to out_data.

## Test plan
- 2×3 stream:
  - Stimulus: m=2, n=3, element k = k+1 across row-major positions, out_ready=1.
  - Response: stream 0x01,0x02,0x03,0x06,0x07,0x08 with tags (0,0)…(1,2). out_last_col on the 3rd and 6th elements; out_last on the 6th only. done exactly one cycle after the 6th transfer.
- Backpressure:
  - Stimulus: 1×2 matrix {0xAA,0x55}; out_ready low for 3 cycles, then toggling.
  - Response: 0xAA held stable with out_valid high until accepted. Exactly two transfers, no duplicates or drops.
- Invalid dimensions:
  - Stimulus: start with m=0, n=3; then start with m=6, n=2.
  - Response: err pulses once each time; busy and out_valid stay 0.
- Full size, with input changes:
  - Stimulus: 5×5 matrix with elements 0x00..0x18; matrix_in altered and start re-pulsed mid-stream.
  - Response: exactly 25 transfers of the original values; the second start is ignored.
- Minimum size:
  - Stimulus: 1×1 matrix {0x7F}.
  - Response: out_last_col=1 and out_last=1 on the single element; done follows.
- Reset mid-stream:
  - Stimulus: assert reset after the 4th transfer of a 3×3 stream.
  - Response: out_valid/busy drop immediately with no done. After release, a new start streams from (0,0).
